// File: rtl/interlaken_tx_framer.sv
// Interlaken TX framer for one lane: buffers user words in a small FIFO and
// builds 64b/67b metaframes (Sync, Scrambler State, Skip, payload/Idle,
// Diagnostic), one word per cycle in which the gearbox signals ready.
module interlaken_tx_framer #(
    parameter int META_FRAME_LEN = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [63:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    input  logic [57:0] SCRAM_STATE_IN,
    input  logic        LANE_STATUS,
    input  logic        LINK_STATUS,
    input  logic        GBX_READY,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_VALID,
    output logic [15:0] FRAME_CNT
);

    localparam int IW = (META_FRAME_LEN > 1) ? $clog2(META_FRAME_LEN) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [IW-1:0] IDX_SYNC  = IW'(0);
    localparam logic [IW-1:0] IDX_SCRAM = IW'(1);
    localparam logic [IW-1:0] IDX_SKIP  = IW'(2);
    localparam logic [IW-1:0] IDX_DIAG  = IW'(META_FRAME_LEN - 1);

    localparam logic [1:0]  HDR_DATA  = 2'b01;
    localparam logic [1:0]  HDR_CTRL  = 2'b10;
    localparam logic [63:0] WORD_SYNC = 64'h78F678F678F678F6;
    localparam logic [63:0] WORD_SKIP = 64'h1E1E1E1E1E1E1E1E;
    localparam logic [63:0] WORD_IDLE = 64'hAAAAAAAAAAAAAAAA;

    // Scrambler State control word: block type 6'b001010 followed by the state.
    function automatic logic [63:0] build_scram(input logic [57:0] state);
        return {6'b001010, state};
    endfunction

    // Diagnostic control word; the CRC32 field stays zero for the CRC inserter.
    function automatic logic [63:0] build_diag(input logic lane, input logic link);
        return {6'b011001, 24'h0, lane, link, 32'h0};
    endfunction

    logic [IW-1:0] idx;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;
    logic          pop_slot;
    logic [63:0]   word_data;
    logic [1:0]    word_hdr;

    // A write needs the registered ready, so a full FIFO never accepts a word.
    assign push = DATA_IN_VALID && DATA_IN_READY;
    assign pop  = GBX_READY && pop_slot;

    // Select the word for the current slot; payload slots drain the FIFO head.
    always_comb begin
        word_data = WORD_IDLE;
        word_hdr  = HDR_CTRL;
        pop_slot  = 1'b0;
        if (idx == IDX_SYNC) begin
            word_data = WORD_SYNC;
        end else if (idx == IDX_SCRAM) begin
            word_data = build_scram(SCRAM_STATE_IN);
        end else if (idx == IDX_SKIP) begin
            word_data = WORD_SKIP;
        end else if (idx == IDX_DIAG) begin
            word_data = build_diag(LANE_STATUS, LINK_STATUS);
        end else if (count != '0) begin
            word_data = mem[rd_ptr];
            word_hdr  = HDR_DATA;
            pop_slot  = 1'b1;
        end
    end

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // FIFO storage holds only data, so it carries no reset.
    always_ff @(posedge USER_CLK) begin
        if (push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            DATA_IN_READY <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            DATA_IN_READY <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // Metaframe slot index and completed-metaframe counter.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            idx       <= '0;
            FRAME_CNT <= 16'h0;
        end else if (GBX_READY) begin
            if (idx == IDX_DIAG) begin
                idx       <= '0;
                FRAME_CNT <= FRAME_CNT + 16'h1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Output register: new word on ready cycles, otherwise hold with valid low.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            DATA_OUT   <= 64'h0;
            HEADER_OUT <= 2'b00;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= GBX_READY;
            if (GBX_READY) begin
                DATA_OUT   <= word_data;
                HEADER_OUT <= word_hdr;
            end
        end
    end

endmodule

// File: tb/tb_interlaken_tx_framer.sv
// Directed testbench for interlaken_tx_framer (META_FRAME_LEN=16, FIFO_DEPTH=4).
module tb_interlaken_tx_framer;

    localparam int MFL = 16;
    localparam int FD  = 4;

    localparam logic [63:0] W_SYNC = 64'h78F678F678F678F6;
    localparam logic [63:0] W_SCR  = 64'h28000000000002AB;
    localparam logic [63:0] W_SKIP = 64'h1E1E1E1E1E1E1E1E;
    localparam logic [63:0] W_IDLE = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] W_DIAG = 64'h6400000200000000;
    localparam logic [1:0]  H_DATA = 2'b01;
    localparam logic [1:0]  H_CTRL = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = 64'h0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [57:0] scram_state = 58'h2AB;
    logic        lane_status = 1'b1;
    logic        link_status = 1'b0;
    logic        gbx_ready = 1'b0;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_valid;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    interlaken_tx_framer #(.META_FRAME_LEN(MFL), .FIFO_DEPTH(FD)) dut (
        .USER_CLK      (clk),
        .SYSTEM_RESET_N(rst_n),
        .DATA_IN       (data_in),
        .DATA_IN_VALID (data_in_valid),
        .DATA_IN_READY (data_in_ready),
        .SCRAM_STATE_IN(scram_state),
        .LANE_STATUS   (lane_status),
        .LINK_STATUS   (link_status),
        .GBX_READY     (gbx_ready),
        .DATA_OUT      (data_out),
        .HEADER_OUT    (header_out),
        .DATA_VALID    (data_valid),
        .FRAME_CNT     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gbx;
        logic        vin;
        logic [63:0] din;
        logic        exp_dv;
        logic [1:0]  exp_hdr;
        logic [63:0] exp_data;
        logic        exp_rdy;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic dv, input logic [1:0] hdr,
                             input logic [63:0] dat, input logic rdy, input logic [15:0] fc);
        chk({tag, ".valid"}, 64'(data_valid), 64'(dv));
        chk({tag, ".header"}, 64'(header_out), 64'(hdr));
        chk({tag, ".data"}, data_out, dat);
        chk({tag, ".ready"}, 64'(data_in_ready), 64'(rdy));
        chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(fc));
    endtask

    // Expected control word for slot i, or the supplied payload/idle word otherwise.
    function automatic logic [63:0] slot_word(input int i, input logic [63:0] pay);
        case (i)
            0:       return W_SYNC;
            1:       return W_SCR;
            2:       return W_SKIP;
            MFL - 1: return W_DIAG;
            default: return pay;
        endcase
    endfunction

    function automatic logic [1:0] slot_hdr(input int i, input logic is_data);
        if (i <= 2 || i == MFL - 1) return H_CTRL;
        return is_data ? H_DATA : H_CTRL;
    endfunction

    function automatic vec_t mk(input logic gbx, input logic vin, input logic [63:0] din,
                                input logic dv, input logic [1:0] hdr, input logic [63:0] dat,
                                input logic rdy, input logic [15:0] fc);
        vec_t v;
        v.gbx = gbx; v.vin = vin; v.din = din;
        v.exp_dv = dv; v.exp_hdr = hdr; v.exp_data = dat;
        v.exp_rdy = rdy; v.exp_fc = fc;
        return v;
    endfunction

    logic        push_v [MFL];
    logic [63:0] push_d [MFL];
    logic        pay_v  [MFL];
    logic [63:0] pay_d  [MFL];

    initial begin
        // Frame 2 stimulus: three pushes on control slots, two pushes that meet
        // pops, and one push landing on a payload slot with the FIFO empty.
        for (int i = 0; i < MFL; i++) begin
            push_v[i] = 1'b0; push_d[i] = 64'h0;
            pay_v[i]  = 1'b0; pay_d[i]  = W_IDLE;
        end
        push_v[0] = 1'b1; push_d[0] = 64'h1;
        push_v[1] = 1'b1; push_d[1] = 64'h2;
        push_v[2] = 1'b1; push_d[2] = 64'h3;
        push_v[3] = 1'b1; push_d[3] = 64'h11;
        push_v[4] = 1'b1; push_d[4] = 64'h12;
        push_v[8] = 1'b1; push_d[8] = 64'h13;
        pay_v[3] = 1'b1; pay_d[3] = 64'h1;
        pay_v[4] = 1'b1; pay_d[4] = 64'h2;
        pay_v[5] = 1'b1; pay_d[5] = 64'h3;
        pay_v[6] = 1'b1; pay_d[6] = 64'h11;
        pay_v[7] = 1'b1; pay_d[7] = 64'h12;
        pay_v[9] = 1'b1; pay_d[9] = 64'h13;

        // Frame 1: no input, all payload slots Idle.
        for (int i = 0; i < MFL; i++)
            vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b1, slot_hdr(i, 1'b0),
                              slot_word(i, W_IDLE), 1'b1, (i == MFL - 1) ? 16'd1 : 16'd0));
        // Frame 2.
        for (int i = 0; i < MFL; i++)
            vecs.push_back(mk(1'b1, push_v[i], push_d[i], 1'b1, slot_hdr(i, pay_v[i]),
                              slot_word(i, pay_d[i]), 1'b1, (i == MFL - 1) ? 16'd2 : 16'd1));

        // Reset state with the gearbox already requesting words.
        gbx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 2'b00, 64'h0, 1'b0, 16'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            gbx_ready     = vecs[k].gbx;
            data_in_valid = vecs[k].vin;
            data_in       = vecs[k].din;
            tick();
            check_out($sformatf("vec%0d", k), vecs[k].exp_dv, vecs[k].exp_hdr,
                      vecs[k].exp_data, vecs[k].exp_rdy, vecs[k].exp_fc);
        end
        data_in_valid = 1'b0;

        // Gearbox ready once every third cycle: same words, held between pulses.
        for (int i = 0; i < MFL; i++) begin
            gbx_ready = 1'b1;
            tick();
            check_out($sformatf("paced%0d", i), 1'b1, slot_hdr(i, 1'b0),
                      slot_word(i, W_IDLE), 1'b1, (i == MFL - 1) ? 16'd3 : 16'd2);
            gbx_ready = 1'b0;
            repeat (2) begin
                tick();
                check_out($sformatf("paced%0d_hold", i), 1'b0, slot_hdr(i, 1'b0),
                          slot_word(i, W_IDLE), 1'b1, (i == MFL - 1) ? 16'd3 : 16'd2);
            end
        end

        // Fill the FIFO with the gearbox stalled; the fifth word must be refused.
        for (int j = 0; j < 5; j++) begin
            data_in       = 64'(4 + j);
            data_in_valid = 1'b1;
            tick();
            chk($sformatf("fill%0d.ready", j), 64'(data_in_ready), (j < 3) ? 64'd1 : 64'd0);
            chk($sformatf("fill%0d.valid", j), 64'(data_valid), 64'd0);
        end
        data_in_valid = 1'b0;
        gbx_ready     = 1'b1;
        for (int i = 0; i < MFL; i++) begin
            logic [63:0] p;
            logic        pv;
            pv = (i >= 3 && i <= 6);
            p  = pv ? 64'(i + 1) : W_IDLE;
            tick();
            check_out($sformatf("drain%0d", i), 1'b1, slot_hdr(i, pv), slot_word(i, p),
                      (i < 3) ? 1'b0 : 1'b1, (i == MFL - 1) ? 16'd4 : 16'd3);
        end

        // Reset mid-metaframe at idx 7 with two words buffered.
        repeat (7) tick();
        gbx_ready     = 1'b0;
        data_in_valid = 1'b1;
        data_in       = 64'hA1;
        tick();
        data_in       = 64'hA2;
        tick();
        data_in_valid = 1'b0;
        chk("pre_reset.frame_cnt", 64'(frame_cnt), 64'd4);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 1'b0, 2'b00, 64'h0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        gbx_ready = 1'b1;
        for (int i = 0; i < MFL; i++) begin
            tick();
            check_out($sformatf("post_reset%0d", i), 1'b1, slot_hdr(i, 1'b0),
                      slot_word(i, W_IDLE), 1'b1, (i == MFL - 1) ? 16'd1 : 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
